multi_channel_pio: RTL
======================

// Module: multi_channel_pio
// PURPOSE
//  Parametrised Avalon-MM PIO; successor to the fixed per-colour/switch PIOs on the nios system.
//  NUM_CH independent channels, each CH_W bits wide, each with:
//   - an output register;
//   - a synchronised input;
//   - edge capture;
//   - a per-bit IRQ mask.
//  One block replaces separate red/green/blue/sw PIOs and adds interrupt-driven input handling.
// PARAMETERS
//  NUM_CH     4         number of channels (1..16)
//  CH_W       8         bits per channel (1..32)
//  EDGE_MODE  2         capture mode: 0 = rising, 1 = falling, 2 = any edge
//  RESET_OUT  0         reset value loaded into every channel's output register (CH_W bits)
//  ADDR_W     derived   clog2(NUM_CH)+2; not user-set
// PORTS
//  clk_clk            in   1          system clock; all logic on rising edge
//  reset_reset        in   1          synchronous, active-high reset
//  avs_address        in   ADDR_W     {channel, reg[1:0]} word address
//  avs_read           in   1          read strobe, single-cycle
//  avs_write          in   1          write strobe, single-cycle
//  avs_writedata      in   32         write data; bits [CH_W-1:0] used
//  avs_readdata       out  32         read data; upper bits zero
//  avs_readdatavalid  out  1          high exactly one cycle per accepted read
//  irq                out  1          level interrupt; OR over all channels of (capture & mask)
//  pio_in             in   NUM_CH*CH_W   asynchronous inputs; channel c at [c*CH_W +: CH_W]
//  pio_out            out  NUM_CH*CH_W   registered outputs; same packing as pio_in
// BEHAVIOUR
//  Reset values:
//   - pio_out = RESET_OUT per channel.
//   - readdata = 0, readdatavalid = 0, irq = 0.
//   - Sync flops, capture and mask registers = 0.
//   - Arm counter = 0.
//  Register map (reg field):
//   0 DATA_OUT  RW
//   1 DATA_IN   RO (synchronised value)
//   2 EDGE_CAP  RW1C
//   3 IRQ_MASK  RW
//  Channel index >= NUM_CH: reads return 0; writes are ignored.
//  Read timing: fixed latency 1. readdata/readdatavalid are registered in the cycle after avs_read.
//  No waitrequest. Back-to-back reads give back-to-back valids.
//  Write timing: the register updates on the clock edge where avs_write=1.
//   - pio_out changes in that same cycle+1.
//   - Byteenable is not supported; full CH_W write.
//  read and write asserted together: both honoured. The read returns the pre-write value.
//  Input path:
//   - 2-flop synchroniser per bit, then a prev register.
//   - edge = f(sync, prev) per EDGE_MODE.
//   - pio_in to DATA_IN visibility: 2 cycles.
//   - pio_in to EDGE_CAP visibility: 3 cycles.
//  Arming:
//   - After reset deassertion, a 2-bit counter runs for 3 cycles.
//   - Edge detection is suppressed until the counter saturates, so no false edges from sync fill.
//  EDGE_CAP update: cap <= (cap & ~w1c_mask) | edge. A new edge in the same cycle as its W1C wins; the bit stays 1.
//  irq is registered: 1 cycle after cap or mask changes.
//  Reset mid-transaction: a pending readdatavalid is dropped; the next cycle shows readdatavalid = 0.
//  Writes to DATA_IN are ignored.
// STRUCTURE
//  Package pio_pkg:
//   - register offsets REG_DATA_OUT..REG_IRQ_MASK;
//   - EDGE_MODE encodings EDGE_RISE/EDGE_FALL/EDGE_ANY;
//   - function clog2.
//  Sub-module pio_channel (one generate instance per channel) holds:
//   - sync, prev, capture, mask and out registers;
//   - a local irq_req output.
//  Top-level holds: address decode, read mux/latency register, arm counter, irq OR/register.
// TESTING
//  1. Reset with RESET_OUT=8'hA5 -> every pio_out channel = A5, irq=0, readdatavalid=0.
//  2. Write ch2 DATA_OUT=8'h3C; read ch2 reg0 -> pio_out[23:16]=3C next cycle; readdata=0000003C with valid 1 cycle after read.
//  3. EDGE_MODE=0; mask ch1=8'h01; raise pio_in[8] -> EDGE_CAP ch1=01 after 3 cycles, irq=1 one cycle later; W1C 01 -> irq=0.
//  4. Edge on bit 0 in the same cycle as its W1C -> EDGE_CAP bit remains 1, irq stays 1.
//  5. Hold pio_in all ones through reset release -> EDGE_CAP stays 0 (arming suppression); DATA_IN reads FF.
//  6. Read channel NUM_CH (out of range) -> readdata=0, valid=1; a write there changes no register.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared register map, edge-mode encodings and elaboration helpers for the multi-channel PIO.
package pio_pkg;

    typedef enum logic [1:0] {
        REG_DATA_OUT = 2'd0,
        REG_DATA_IN  = 2'd1,
        REG_EDGE_CAP = 2'd2,
        REG_IRQ_MASK = 2'd3
    } pio_reg_e;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    localparam int unsigned BUS_W = 32;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/multi_channel_pio_if.sv
// Avalon-MM slave bus bundle for the multi-channel PIO (fixed read latency, no waitrequest).
interface multi_channel_pio_if #(
    parameter int unsigned ADDR_W = 4
) ();

    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata,
        input  avs_readdatavalid
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata,
        output avs_readdatavalid
    );

endinterface

// File: rtl/pio_channel.sv
// One PIO channel: output register, 2-flop input synchroniser, edge capture and IRQ mask.
module pio_channel
    import pio_pkg::*;
#(
    parameter int unsigned     CH_W      = 8,
    parameter int unsigned     EDGE_MODE = EDGE_ANY,
    parameter logic [CH_W-1:0] RESET_OUT = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            edge_en,
    input  logic [CH_W-1:0] pin,
    input  logic            wr_out,
    input  logic            wr_cap,
    input  logic            wr_mask,
    input  logic [CH_W-1:0] wdata,
    output logic [CH_W-1:0] out_q,
    output logic [CH_W-1:0] sync_q,
    output logic [CH_W-1:0] cap_q,
    output logic [CH_W-1:0] mask_q,
    output logic            irq_req_c
);

    logic [CH_W-1:0] meta_q;
    logic [CH_W-1:0] prev_q;
    logic [CH_W-1:0] meta_d;
    logic [CH_W-1:0] sync_d;
    logic [CH_W-1:0] prev_d;
    logic [CH_W-1:0] out_d;
    logic [CH_W-1:0] cap_d;
    logic [CH_W-1:0] mask_d;
    logic [CH_W-1:0] det_c;

    always_comb begin
        meta_d = pin;
        sync_d = meta_q;
        prev_d = sync_q;
        det_c  = '0;

        if (EDGE_MODE == EDGE_RISE) begin
            det_c = sync_q & ~prev_q;
        end else if (EDGE_MODE == EDGE_FALL) begin
            det_c = ~sync_q & prev_q;
        end else begin
            det_c = sync_q ^ prev_q;
        end
        if (!edge_en) begin
            det_c = '0;
        end

        out_d  = wr_out  ? wdata : out_q;
        mask_d = wr_mask ? wdata : mask_q;
        // A fresh edge outranks a simultaneous clear of the same bit.
        cap_d  = (cap_q & ~(wr_cap ? wdata : '0)) | det_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
            out_q  <= RESET_OUT;
            cap_q  <= '0;
            mask_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            out_q  <= out_d;
            cap_q  <= cap_d;
            mask_q <= mask_d;
        end
    end

    assign irq_req_c = |(cap_q & mask_q);

endmodule

// File: rtl/multi_channel_pio.sv
// Parametrised Avalon-MM PIO: address decode, latency-1 read mux, arming counter and IRQ aggregation.
module multi_channel_pio
    import pio_pkg::*;
#(
    parameter int unsigned     NUM_CH    = 4,
    parameter int unsigned     CH_W      = 8,
    parameter int unsigned     EDGE_MODE = EDGE_ANY,
    parameter logic [CH_W-1:0] RESET_OUT = '0
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    multi_channel_pio_if.slave     avs,
    output logic                   irq,
    input  logic [NUM_CH*CH_W-1:0] pio_in,
    output logic [NUM_CH*CH_W-1:0] pio_out
);

    localparam int unsigned ADDR_W = clog2(NUM_CH) + 2;

    logic [ADDR_W-1:0] addr_c;
    logic [31:0]       ch_idx_c;
    pio_reg_e          reg_sel_c;
    logic [CH_W-1:0]   wdata_c;
    logic [CH_W-1:0]   rdata_c;
    logic              unused_wdata;

    logic [NUM_CH-1:0] wr_out_c;
    logic [NUM_CH-1:0] wr_cap_c;
    logic [NUM_CH-1:0] wr_mask_c;
    logic [NUM_CH-1:0] irq_req_c;

    logic [CH_W-1:0]   ch_out_q  [NUM_CH];
    logic [CH_W-1:0]   ch_in_q   [NUM_CH];
    logic [CH_W-1:0]   ch_cap_q  [NUM_CH];
    logic [CH_W-1:0]   ch_mask_q [NUM_CH];

    logic [BUS_W-1:0]  readdata_q;
    logic [BUS_W-1:0]  readdata_d;
    logic              readdatavalid_q;
    logic              readdatavalid_d;
    logic [1:0]        arm_q;
    logic [1:0]        arm_d;
    logic              irq_q;
    logic              irq_d;
    logic              armed_c;

    assign addr_c       = avs.avs_address;
    assign ch_idx_c     = 32'(addr_c >> 2);
    assign reg_sel_c    = pio_reg_e'(addr_c[1:0]);
    assign wdata_c      = avs.avs_writedata[CH_W-1:0];
    assign unused_wdata = ^avs.avs_writedata;
    assign armed_c      = (arm_q == 2'd3);

    // Decode: out-of-range channels match no loop index, so they read 0 and ignore writes.
    always_comb begin
        wr_out_c  = '0;
        wr_cap_c  = '0;
        wr_mask_c = '0;
        rdata_c   = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_idx_c == c) begin
                unique case (reg_sel_c)
                    REG_DATA_OUT: begin
                        rdata_c     = ch_out_q[c];
                        wr_out_c[c] = avs.avs_write;
                    end
                    REG_DATA_IN: begin
                        rdata_c = ch_in_q[c];
                    end
                    REG_EDGE_CAP: begin
                        rdata_c     = ch_cap_q[c];
                        wr_cap_c[c] = avs.avs_write;
                    end
                    REG_IRQ_MASK: begin
                        rdata_c      = ch_mask_q[c];
                        wr_mask_c[c] = avs.avs_write;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            pio_channel #(
                .CH_W      (CH_W),
                .EDGE_MODE (EDGE_MODE),
                .RESET_OUT (RESET_OUT)
            ) u_ch (
                .clk       (clk_clk),
                .rst       (reset_reset),
                .edge_en   (armed_c),
                .pin       (pio_in[g*CH_W +: CH_W]),
                .wr_out    (wr_out_c[g]),
                .wr_cap    (wr_cap_c[g]),
                .wr_mask   (wr_mask_c[g]),
                .wdata     (wdata_c),
                .out_q     (ch_out_q[g]),
                .sync_q    (ch_in_q[g]),
                .cap_q     (ch_cap_q[g]),
                .mask_q    (ch_mask_q[g]),
                .irq_req_c (irq_req_c[g])
            );
            assign pio_out[g*CH_W +: CH_W] = ch_out_q[g];
        end
    endgenerate

    // Read data reflects pre-write state, so a same-cycle read/write returns the old value.
    always_comb begin
        readdata_d      = avs.avs_read ? BUS_W'(rdata_c) : readdata_q;
        readdatavalid_d = avs.avs_read;
        arm_d           = armed_c ? arm_q : arm_q + 2'd1;
        irq_d           = |irq_req_c;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
            arm_q           <= 2'd0;
            irq_q           <= 1'b0;
        end else begin
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
            arm_q           <= arm_d;
            irq_q           <= irq_d;
        end
    end

    assign avs.avs_readdata      = readdata_q;
    assign avs.avs_readdatavalid = readdatavalid_q;
    assign irq                   = irq_q;

endmodule
